// File: rtl/cpu_boot_pkg.sv
// Shared types and constants for the cpu boot/run controller.
package cpu_boot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StRun,
        StDone,
        StError
    } boot_state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;

    localparam logic [5:0] STOP_OPCODE = 6'b111110;
    localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/boot_run_counter.sv
// Run-cycle counter with synchronous clear and a flag for the increment that reaches MAX_CYCLES.
module boot_run_counter #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             timeout
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Raised in the cycle whose increment lands the count on MAX_CYCLES.
    assign timeout = inc && (cnt_q == CNT_W'(MAX_CYCLES - 1));
    assign cnt     = cnt_q;

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot controller: streams host words into per-channel memories, then runs the cpu until STOP.
module cpu_boot_ctrl
    import cpu_boot_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned CH_DEPTH   = 1024,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 1000000,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     start,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_last,
    output logic [NUM_CH-1:0]        wen_ext,
    output logic [NUM_CH-1:0]        ren_ext,
    output logic [NUM_CH*ADDR_W-1:0] addr_ext,
    output logic [NUM_CH*DATA_W-1:0] wdata_ext,
    output logic                     enable,
    input  logic [DATA_W-1:0]        instruction,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [1:0]               test_id,
    output logic [CNT_W-1:0]         cycle_cnt
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned IDX_W = $clog2(CH_DEPTH + 1);
    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);

    boot_state_e                   state_q, state_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [IDX_W-1:0]              widx_q, widx_d;
    logic [SET_W-1:0]              settle_q, settle_d;
    logic [NUM_CH-1:0]             wen_q, wen_d;
    logic [NUM_CH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [NUM_CH-1:0][DATA_W-1:0] wdata_q, wdata_d;
    logic                          enable_q, enable_d;
    logic [1:0]                    err_code_q, err_code_d;
    logic [1:0]                    test_id_q, test_id_d;
    logic                          xfer, stop_hit, launch, timeout;

    assign s_ready  = (state_q == StLoad);
    assign xfer     = s_valid && s_ready;
    assign stop_hit = (instruction[DATA_W-1 -: 6] == STOP_OPCODE);
    assign launch   = start && (state_q inside {StIdle, StDone, StError});

    boot_run_counter #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_run_counter (
        .clk     (clk),
        .arst    (arst),
        .clr     (launch),
        .inc     (state_q == StRun),
        .cnt     (cycle_cnt),
        .timeout (timeout)
    );

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        widx_d     = widx_q;
        settle_d   = '0;
        wen_d      = '0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_code_d = err_code_q;
        test_id_d  = test_id_q;

        case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d    = StLoad;
                    ch_d       = '0;
                    widx_d     = '0;
                    err_code_d = ERR_NONE;
                    test_id_d  = '0;
                end
            end
            StLoad: begin
                if (xfer) begin
                    // A beat beyond the channel depth is dropped rather than written.
                    if (widx_q == IDX_W'(CH_DEPTH)) begin
                        state_d    = StError;
                        err_code_d = ERR_OVF;
                    end else begin
                        wen_d[ch_q]   = 1'b1;
                        addr_d[ch_q]  = ADDR_W'(widx_q) << WORD_SHIFT;
                        wdata_d[ch_q] = s_data;
                        if (s_last) begin
                            widx_d = '0;
                            if (ch_q == CH_W'(NUM_CH - 1)) begin
                                state_d = StSettle;
                            end else begin
                                ch_d = ch_q + CH_W'(1);
                            end
                        end else begin
                            widx_d = widx_q + IDX_W'(1);
                        end
                    end
                end
            end
            StSettle: begin
                if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                    state_d = StRun;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            StRun: begin
                // STOP takes priority over a coincident timeout.
                if (stop_hit) begin
                    state_d   = StDone;
                    test_id_d = instruction[1:0];
                end else if (timeout) begin
                    state_d    = StError;
                    err_code_d = ERR_TMO;
                end
            end
            default: state_d = StIdle;
        endcase

        enable_d = (state_d == StRun);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= StIdle;
            ch_q       <= '0;
            widx_q     <= '0;
            settle_q   <= '0;
            wen_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            enable_q   <= 1'b0;
            err_code_q <= ERR_NONE;
            test_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            widx_q     <= widx_d;
            settle_q   <= settle_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            enable_q   <= enable_d;
            err_code_q <= err_code_d;
            test_id_q  <= test_id_d;
        end
    end

    assign wen_ext   = wen_q;
    assign ren_ext   = '0;
    assign addr_ext  = addr_q;
    assign wdata_ext = wdata_q;
    assign enable    = enable_q;
    assign busy      = state_q inside {StLoad, StSettle, StRun};
    assign done      = (state_q == StDone);
    assign err       = (state_q == StError);
    assign err_code  = err_code_q;
    assign test_id   = test_id_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench for cpu_boot_ctrl: load, backpressure, STOP, overflow, timeout, mid-run reset.
module tb_cpu_boot_ctrl;

    localparam int NCH = 2;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int CW  = 32;

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic [DW-1:0]     s_data = '0;
    logic [DW-1:0]     instruction = '0;
    logic              s_ready, enable, busy, done, err;
    logic [NCH-1:0]    wen_ext, ren_ext;
    logic [NCH*AW-1:0] addr_ext;
    logic [NCH*DW-1:0] wdata_ext;
    logic [1:0]        err_code, test_id;
    logic [CW-1:0]     cycle_cnt;

    int total = 0;
    int bad   = 0;

    int          wl_ch[$];
    logic [31:0] wl_addr[$];
    logic [31:0] wl_data[$];
    logic        en_seen = 1'b0;

    cpu_boot_ctrl #(
        .NUM_CH     (NCH),
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .CH_DEPTH   (4),
        .CNT_W      (CW),
        .MAX_CYCLES (20),
        .SETTLE_CYC (1)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .start       (start),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .addr_ext    (addr_ext),
        .wdata_ext   (wdata_ext),
        .enable      (enable),
        .instruction (instruction),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .test_id     (test_id),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    // Write log sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (wen_ext[c]) begin
                wl_ch.push_back(c);
                wl_addr.push_back(addr_ext[c*AW +: AW]);
                wl_data.push_back(wdata_ext[c*DW +: DW]);
            end
        end
        if (enable) en_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        wl_ch.delete();
        wl_addr.delete();
        wl_data.delete();
    endtask

    task automatic chk_wr(input int i, input int ch, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] oc, oa, od;
        oc = 'x;
        oa = 'x;
        od = 'x;
        if (i < wl_ch.size()) begin
            oc = wl_ch[i];
            oa = wl_addr[i];
            od = wl_data[i];
        end
        chk($sformatf("wr%0d_ch", i), oc, ch);
        chk($sformatf("wr%0d_addr", i), oa, a);
        chk($sformatf("wr%0d_data", i), od, d);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_enable"}, enable, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_code"}, err_code, 0);
        chk({tag, "_test_id"}, test_id, 0);
        chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_wen"}, wen_ext, 0);
        chk({tag, "_ren"}, ren_ext, 0);
        chk({tag, "_addr"}, addr_ext, 0);
        chk({tag, "_wdata"}, wdata_ext, 0);
    endtask

    initial begin
        // Reset state
        tick();
        chk_zero("rst");
        arst = 1'b0;

        // Basic load then STOP on 5th RUN cycle
        pulse_start();
        chk("load_busy", busy, 1);
        chk("load_ready", s_ready, 1);
        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        send(32'h33, 1'b1);
        send(32'h44, 1'b0);
        send(32'h55, 1'b1);
        chk("settle_ready", s_ready, 0);
        chk("settle_enable", enable, 0);
        chk("settle_busy", busy, 1);
        tick();
        chk("run_enable", enable, 1);
        chk("run_cnt0", cycle_cnt, 0);
        chk("basic_nwr", wl_ch.size(), 5);
        chk_wr(0, 0, 32'h0, 32'h11);
        chk_wr(1, 0, 32'h4, 32'h22);
        chk_wr(2, 0, 32'h8, 32'h33);
        chk_wr(3, 1, 32'h0, 32'h44);
        chk_wr(4, 1, 32'h4, 32'h55);
        repeat (4) tick();
        chk("pre_stop_cnt", cycle_cnt, 4);
        chk("pre_stop_enable", enable, 1);
        instruction = 32'hF800_0002;
        tick();
        instruction = '0;
        chk("stop_done", done, 1);
        chk("stop_test_id", test_id, 2);
        chk("stop_cnt", cycle_cnt, 5);
        chk("stop_enable", enable, 0);
        chk("stop_busy", busy, 0);
        tick();
        chk("done_hold_cnt", cycle_cnt, 5);
        chk("done_hold", done, 1);

        // Backpressure gaps, then timeout
        clear_log();
        pulse_start();
        chk("restart_done", done, 0);
        chk("restart_cnt", cycle_cnt, 0);
        chk("restart_tid", test_id, 0);
        send(32'hA0, 1'b0);
        tick();
        send(32'hA1, 1'b1);
        tick();
        send(32'hB0, 1'b0);
        tick();
        send(32'hB1, 1'b0);
        tick();
        send(32'hB2, 1'b1);
        tick();
        chk("bp_nwr", wl_ch.size(), 5);
        chk_wr(0, 0, 32'h0, 32'hA0);
        chk_wr(1, 0, 32'h4, 32'hA1);
        chk_wr(2, 1, 32'h0, 32'hB0);
        chk_wr(3, 1, 32'h4, 32'hB1);
        chk_wr(4, 1, 32'h8, 32'hB2);
        repeat (19) tick();
        chk("tmo_pre_cnt", cycle_cnt, 19);
        chk("tmo_pre_err", err, 0);
        tick();
        chk("tmo_err", err, 1);
        chk("tmo_code", err_code, 2);
        chk("tmo_cnt", cycle_cnt, 20);
        chk("tmo_enable", enable, 0);
        tick();
        chk("tmo_hold_cnt", cycle_cnt, 20);

        // STOP coincident with timeout: STOP wins
        pulse_start();
        chk("rs_err", err, 0);
        chk("rs_code", err_code, 0);
        send(32'h1, 1'b1);
        send(32'h2, 1'b1);
        tick();
        repeat (19) tick();
        instruction = 32'hF800_0001;
        tick();
        instruction = '0;
        chk("race_done", done, 1);
        chk("race_err", err, 0);
        chk("race_code", err_code, 0);
        chk("race_tid", test_id, 1);
        chk("race_cnt", cycle_cnt, 20);

        // Overflow on a 4-deep channel
        clear_log();
        en_seen = 1'b0;
        pulse_start();
        for (int i = 0; i < 5; i++) send(32'hC0 + i, 1'b0);
        chk("ovf_err", err, 1);
        chk("ovf_code", err_code, 1);
        chk("ovf_ready", s_ready, 0);
        tick();
        chk("ovf_nwr", wl_ch.size(), 4);
        for (int i = 0; i < 4; i++) chk_wr(i, 0, 32'(i * 4), 32'hC0 + i);
        chk("ovf_en_seen", en_seen, 0);

        // Reset mid-run, then reload
        pulse_start();
        send(32'hD0, 1'b1);
        send(32'hD1, 1'b1);
        tick();
        repeat (6) tick();
        chk("mid_cnt", cycle_cnt, 6);
        chk("mid_wdata_live", wdata_ext, {32'hD1, 32'hD0});
        #2 arst = 1'b1;
        #1;
        chk_zero("arst");
        #1 arst = 1'b0;
        tick();
        clear_log();
        pulse_start();
        send(32'hE0, 1'b0);
        send(32'hE1, 1'b1);
        send(32'hE2, 1'b1);
        tick();
        chk("rl_enable", enable, 1);
        pulse_start();
        chk("rl_start_ignored_cnt", cycle_cnt, 1);
        chk("rl_start_ignored_busy", busy, 1);
        tick();
        instruction = 32'hF800_0003;
        tick();
        instruction = '0;
        chk("rl_done", done, 1);
        chk("rl_tid", test_id, 3);
        chk("rl_cnt", cycle_cnt, 3);
        chk("rl_nwr", wl_ch.size(), 3);
        chk_wr(0, 0, 32'h0, 32'hE0);
        chk_wr(1, 0, 32'h4, 32'hE1);
        chk_wr(2, 1, 32'h0, 32'hE2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
